execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
//  Y86-64 sequential-processor execute stage: ALU, condition-code register (ZF/SF/OF) and branch/cmov condition.
//  Sits between fetch and the register-file/decode-writeback block.
//  Produces valE and cnd for that block; cnd gates cmovXX writeback (icode 2).
//  Holds the only architectural CC state, plus a sticky halt flag that freezes CC after HALT.
// PARAMETERS
//  WIDTH     64  datapath width (valA/valB/valC/valE)
//  STACK_INC 8   stack-pointer adjust for call/ret/pushq/popq
// PORTS
//  clk    input   1      rising-edge clock, shared with register file
//  rst_n  input   1      asynchronous, active-low reset
//  icode  input   4      instruction code from fetch
//  ifun   input   4      function code from fetch
//  valA   input   WIDTH  operand A from decode
//  valB   input   WIDTH  operand B from decode
//  valC   input   WIDTH  immediate/displacement from fetch
//  valE   output  WIDTH  ALU result (combinational)
//  cnd    output  1      condition result for jXX/cmovXX (combinational, from current CC)
//  zf     output  1      CC zero flag (registered)
//  sf     output  1      CC sign flag (registered)
//  of     output  1      CC overflow flag (registered)
//  halted output  1      sticky: set after a HALT is executed
//  err    output  1      invalid ifun for OPq/jXX/cmovXX, or icode > 11 (combinational)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - zf=1, sf=0, of=0, halted=0; held until rst_n deasserts.
//   - Combinational outputs keep following inputs during reset.
//  valE by icode (two's complement, wrap mod 2^WIDTH, no saturation):
//   - 2: valA.  3: valC.  4/5: valB+valC.
//   - 6: ifun 0 valB+valA; 1 valB-valA; 2 valB&valA; 3 valB^valA.
//   - 8/10: valB-STACK_INC.  9/11: valB+STACK_INC.  All others: 0.
//  OPq flags:
//   - ZF = (valE==0).  SF = valE[WIDTH-1].
//   - OF add: A,B same sign and valE sign differs.
//   - OF sub: A,B differ in sign and valE sign != B sign.
//   - OF for and/xor: 0.
//  CC update:
//   - Latched on posedge clk only when icode==6, ifun<=3 and halted==0.
//   - Otherwise CC holds.
//   - cnd/valE computed from CC value before the edge; new flags visible the cycle after the OPq.
//  cnd (icode 2 or 7 only, else 0):
//   - ifun 0 always 1.  1 le (SF^OF)|ZF.  2 l SF^OF.  3 e ZF.
//   - 4 ne ~ZF.  5 ge ~(SF^OF).  6 g ~(SF^OF)&~ZF.
//  err / invalid ifun:
//   - err=1 for icode 6 with ifun>3, icode 2/7 with ifun>6, or icode>11.
//   - In that case valE=0, cnd=0, CC not updated.
//  halted:
//   - Set on posedge when icode==0.
//   - Once set: CC frozen, cleared only by reset.
//   - valE/cnd still computed.
//  Reset asserted mid-instruction: CC returns to reset values immediately; no partial update.
// TESTING
//  1. Reset, then icode=7 ifun=3 -> cnd=1 (ZF=1); ifun=4 -> cnd=0.
//  2. icode=6 ifun=0, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> valE=0x8000_0000_0000_0000; next cycle zf=0 sf=1 of=1, jl cnd=0, jle cnd=0.
//  3. icode=6 ifun=1, A=5, B=5 -> valE=0, next zf=1; icode=2 ifun=3 -> cnd=1, valE=valA.
//  4. icode=6 ifun=7 -> err=1, valE=0, CC unchanged; icode=12 -> err=1.
//  5. icode=10, valB=0x100 -> valE=0xF8; icode=11, valB=0xF8 -> valE=0x100; CC unchanged.
//  6. icode=0 one cycle -> halted=1; then OPq producing zero -> zf unchanged; drop rst_n mid-cycle -> halted=0, zf=1 asynchronously.

Source files
------------

// File: rtl/execute.sv
// Y86-64 execute stage: ALU, ZF/SF/OF condition codes, jXX/cmovXX condition, sticky halt.
// Latency: valE/cnd/err are combinational; CC and halted update on the clock edge after an OPq/HALT.
// Backpressure: none; one instruction is consumed every cycle.
// Ports: clk/rst_n (async active-low); icode/ifun from fetch; valA/valB from decode;
//        valC immediate; valE ALU result; cnd branch/cmov condition; zf/sf/of CC;
//        halted sticky halt flag; err invalid icode/ifun.
module execute #(
  parameter int WIDTH     = 64,
  parameter int STACK_INC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             halted,
  output logic             err
);

  localparam logic [3:0] I_HALT  = 4'd0;
  localparam logic [3:0] I_CMOV  = 4'd2;
  localparam logic [3:0] I_IRMOV = 4'd3;
  localparam logic [3:0] I_RMMOV = 4'd4;
  localparam logic [3:0] I_MRMOV = 4'd5;
  localparam logic [3:0] I_OPQ   = 4'd6;
  localparam logic [3:0] I_JXX   = 4'd7;
  localparam logic [3:0] I_CALL  = 4'd8;
  localparam logic [3:0] I_RET   = 4'd9;
  localparam logic [3:0] I_PUSH  = 4'd10;
  localparam logic [3:0] I_POP   = 4'd11;

  localparam logic [WIDTH-1:0] STACK_ADJ = WIDTH'(STACK_INC);

  logic is_cond;
  logic cc_we;
  logic opq_zf;
  logic opq_sf;
  logic opq_of;
  logic a_sign;
  logic b_sign;
  logic e_sign;

  assign is_cond = (icode == I_CMOV) || (icode == I_JXX);

  assign err = ((icode == I_OPQ) && (ifun > 4'd3)) ||
               (is_cond && (ifun > 4'd6)) ||
               (icode > I_POP);

  // Only a valid OPq retires flags, and never once the core has halted.
  assign cc_we = (icode == I_OPQ) && (ifun <= 4'd3) && !halted;

  always_comb begin
    valE = '0;
    case (icode)
      I_CMOV:          if (ifun <= 4'd6) valE = valA;
      I_IRMOV:         valE = valC;
      I_RMMOV, I_MRMOV: valE = valB + valC;
      I_OPQ: begin
        case (ifun)
          4'd0:    valE = valB + valA;
          4'd1:    valE = valB - valA;
          4'd2:    valE = valB & valA;
          4'd3:    valE = valB ^ valA;
          default: valE = '0;
        endcase
      end
      I_CALL, I_PUSH:  valE = valB - STACK_ADJ;
      I_RET, I_POP:    valE = valB + STACK_ADJ;
      default:         valE = '0;
    endcase
  end

  assign a_sign = valA[WIDTH-1];
  assign b_sign = valB[WIDTH-1];
  assign e_sign = valE[WIDTH-1];
  assign opq_zf = (valE == '0);
  assign opq_sf = e_sign;

  // Subtraction computes B-A, so overflow is judged against B's sign.
  always_comb begin
    opq_of = 1'b0;
    case (ifun)
      4'd0:    opq_of = (a_sign == b_sign) && (e_sign != b_sign);
      4'd1:    opq_of = (a_sign != b_sign) && (e_sign != b_sign);
      default: opq_of = 1'b0;
    endcase
  end

  // Condition is evaluated from the CC as it stands before this edge.
  always_comb begin
    cnd = 1'b0;
    if (is_cond) begin
      case (ifun)
        4'd0:    cnd = 1'b1;
        4'd1:    cnd = (sf ^ of) | zf;
        4'd2:    cnd = sf ^ of;
        4'd3:    cnd = zf;
        4'd4:    cnd = ~zf;
        4'd5:    cnd = ~(sf ^ of);
        4'd6:    cnd = ~(sf ^ of) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf     <= 1'b1;
      sf     <= 1'b0;
      of     <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (cc_we) begin
        zf <= opq_zf;
        sf <= opq_sf;
        of <= opq_of;
      end
      if (icode == I_HALT) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the Y86-64 execute stage: directed scenarios plus
// randomized instructions compared against a flag/value reference model.
module tb_execute;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic [W-1:0] valE;
  logic         cnd;
  logic         zf;
  logic         sf;
  logic         of;
  logic         halted;
  logic         err;

  int tests = 0;
  int fails = 0;

  // Reference architectural state
  logic m_zf, m_sf, m_of, m_halt;

  execute #(.WIDTH(W), .STACK_INC(8)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC), .valE(valE), .cnd(cnd),
    .zf(zf), .sf(sf), .of(of), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic ref_err(input logic [3:0] ic, input logic [3:0] fn);
    if (ic > 4'd11) return 1'b1;
    if (ic == 4'd6) return fn > 4'd3;
    if (ic == 4'd2 || ic == 4'd7) return fn > 4'd6;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
    if (ref_err(ic, fn)) return '0;
    case (ic)
      4'd2:        return a;
      4'd3:        return c;
      4'd4, 4'd5:  return b + c;
      4'd6: begin
        if (fn == 4'd0) return b + a;
        if (fn == 4'd1) return b - a;
        if (fn == 4'd2) return b & a;
        return b ^ a;
      end
      4'd8, 4'd10: return b - 64'd8;
      4'd9, 4'd11: return b + 64'd8;
      default:     return '0;
    endcase
  endfunction

  // Overflow = exact signed result does not fit in W bits.
  function automatic logic ref_of(input logic [3:0] fn, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    logic signed [W:0] sa, sb, full;
    sa = {a[W-1], a};
    sb = {b[W-1], b};
    if (fn == 4'd0)      full = sb + sa;
    else if (fn == 4'd1) full = sb - sa;
    else return 1'b0;
    return full[W] != full[W-1];
  endfunction

  function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn);
    logic lt;
    lt = m_sf ^ m_of;
    if (!(ic == 4'd2 || ic == 4'd7)) return 1'b0;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt | m_zf;
      4'd2: return lt;
      4'd3: return m_zf;
      4'd4: return !m_zf;
      4'd5: return !lt;
      4'd6: return !lt && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    #2;
  endtask

  // Advance one clock, updating the model from the instruction presented before the edge.
  task automatic tick();
    logic [W-1:0] e;
    if (!m_halt && icode == 4'd6 && ifun <= 4'd3) begin
      e = ref_vale(icode, ifun, valA, valB, valC);
      m_zf = (e == '0);
      m_sf = e[W-1];
      m_of = ref_of(ifun, valA, valB);
    end
    if (icode == 4'd0) m_halt = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    icode = 4'd1; ifun = 4'd0; valA = '0; valB = '0; valC = '0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_halt = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    icode = 4'd3; ifun = 4'd0; valA = '0; valB = '0; valC = 64'h1234_5678_9abc_def0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_halt = 1'b0;
    #12;
    tests++;
    if ({zf, sf, of, halted} !== 4'b1000) begin
      fails++; $display("FAIL reset_cc got %b exp %b", {zf, sf, of, halted}, 4'b1000);
    end
    tests++;
    if (valE !== 64'h1234_5678_9abc_def0) begin
      fails++; $display("FAIL reset_comb_vale got %h exp %h", valE, 64'h1234_5678_9abc_def0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(4'd7, 4'd3, '0, '0, '0);
    tests++;
    if (cnd !== 1'b1) begin fails++; $display("FAIL reset_je got %b exp 1", cnd); end
    apply(4'd7, 4'd4, '0, '0, '0);
    tests++;
    if (cnd !== 1'b0) begin fails++; $display("FAIL reset_jne got %b exp 0", cnd); end
  endtask

  task automatic test_add_overflow();
    apply(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0);
    tests++;
    if (valE !== 64'h8000_0000_0000_0000) begin
      fails++; $display("FAIL add_vale got %h exp %h", valE, 64'h8000_0000_0000_0000);
    end
    tests++;
    if (zf !== 1'b1) begin fails++; $display("FAIL add_cc_before_edge zf got %b exp 1", zf); end
    tick();
    tests++;
    if ({zf, sf, of} !== 3'b011) begin
      fails++; $display("FAIL add_flags got %b exp %b", {zf, sf, of}, 3'b011);
    end
    apply(4'd7, 4'd2, '0, '0, '0);
    tests++;
    if (cnd !== 1'b0) begin fails++; $display("FAIL add_jl got %b exp 0", cnd); end
    apply(4'd7, 4'd1, '0, '0, '0);
    tests++;
    if (cnd !== 1'b0) begin fails++; $display("FAIL add_jle got %b exp 0", cnd); end
  endtask

  task automatic test_sub_zero_cmov();
    apply(4'd6, 4'd1, 64'd5, 64'd5, '0);
    tests++;
    if (valE !== 64'd0) begin fails++; $display("FAIL sub_vale got %h exp 0", valE); end
    tick();
    tests++;
    if ({zf, sf, of} !== 3'b100) begin
      fails++; $display("FAIL sub_flags got %b exp %b", {zf, sf, of}, 3'b100);
    end
    apply(4'd2, 4'd3, 64'hDEAD_BEEF_0000_0001, 64'd9, 64'd7);
    tests++;
    if (cnd !== 1'b1) begin fails++; $display("FAIL cmove_cnd got %b exp 1", cnd); end
    tests++;
    if (valE !== 64'hDEAD_BEEF_0000_0001) begin
      fails++; $display("FAIL cmove_vale got %h exp %h", valE, 64'hDEAD_BEEF_0000_0001);
    end
    tick();
  endtask

  task automatic test_invalid();
    apply(4'd6, 4'd7, 64'd3, 64'd4, '0);
    tests++;
    if ({err, valE} !== {1'b1, 64'd0}) begin
      fails++; $display("FAIL opq_bad err/vale got %b/%h exp 1/0", err, valE);
    end
    tick();
    tests++;
    if ({zf, sf, of} !== {m_zf, m_sf, m_of} || zf !== 1'b1) begin
      fails++; $display("FAIL opq_bad_cc got %b exp %b", {zf, sf, of}, {m_zf, m_sf, m_of});
    end
    apply(4'd2, 4'd7, 64'd11, '0, '0);
    tests++;
    if ({err, cnd, valE} !== {1'b1, 1'b0, 64'd0}) begin
      fails++; $display("FAIL cmov_bad got %b/%b/%h exp 1/0/0", err, cnd, valE);
    end
    apply(4'd12, 4'd0, 64'd1, 64'd2, 64'd3);
    tests++;
    if ({err, valE} !== {1'b1, 64'd0}) begin
      fails++; $display("FAIL icode12 got %b/%h exp 1/0", err, valE);
    end
    tick();
  endtask

  task automatic test_stack();
    apply(4'd10, 4'd0, '0, 64'h100, '0);
    tests++;
    if (valE !== 64'hF8) begin fails++; $display("FAIL pushq_vale got %h exp f8", valE); end
    tick();
    apply(4'd11, 4'd0, '0, 64'hF8, '0);
    tests++;
    if (valE !== 64'h100) begin fails++; $display("FAIL popq_vale got %h exp 100", valE); end
    tick();
    tests++;
    if ({zf, sf, of} !== {m_zf, m_sf, m_of}) begin
      fails++; $display("FAIL stack_cc got %b exp %b", {zf, sf, of}, {m_zf, m_sf, m_of});
    end
  endtask

  task automatic test_random();
    logic [3:0]   ic, fn;
    logic [W-1:0] a, b, c, ev;
    logic         ec;
    for (int i = 0; i < 400; i++) begin
      ic = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) ic = 4'd6;
      else if ($urandom_range(0, 3) == 0) ic = 4'd7;
      fn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 64'h8000_0000_0000_0000;
        2: b = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      apply(ic, fn, a, b, c);
      ev = ref_vale(ic, fn, a, b, c);
      ec = ref_cnd(ic, fn);
      tests++;
      if (valE !== ev) begin
        fails++; $display("FAIL rand_vale[%0d] ic=%0d fn=%0d got %h exp %h", i, ic, fn, valE, ev);
      end
      tests++;
      if (cnd !== ec) begin
        fails++; $display("FAIL rand_cnd[%0d] ic=%0d fn=%0d got %b exp %b", i, ic, fn, cnd, ec);
      end
      tests++;
      if (err !== ref_err(ic, fn)) begin
        fails++; $display("FAIL rand_err[%0d] ic=%0d fn=%0d got %b exp %b", i, ic, fn, err, ref_err(ic, fn));
      end
      tick();
      tests++;
      if ({zf, sf, of, halted} !== {m_zf, m_sf, m_of, m_halt}) begin
        fails++; $display("FAIL rand_cc[%0d] got %b exp %b", i, {zf, sf, of, halted}, {m_zf, m_sf, m_of, m_halt});
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    apply(4'd6, 4'd0, 64'd1, 64'd2, '0);
    tick();
    apply(4'd0, 4'd0, '0, '0, '0);
    tick();
    tests++;
    if ({halted, zf} !== 2'b10) begin
      fails++; $display("FAIL halt_set got halted/zf %b exp 10", {halted, zf});
    end
    apply(4'd6, 4'd1, 64'd9, 64'd9, '0);
    tests++;
    if (valE !== 64'd0) begin fails++; $display("FAIL halt_vale got %h exp 0", valE); end
    tick();
    tests++;
    if ({zf, halted} !== 2'b01) begin
      fails++; $display("FAIL halt_cc_frozen got zf/halted %b exp 01", {zf, halted});
    end
    // Drop reset between edges; flags must clear without waiting for a clock.
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({zf, sf, of, halted} !== 4'b1000) begin
      fails++; $display("FAIL async_reset got %b exp %b", {zf, sf, of, halted}, 4'b1000);
    end
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_halt = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero_cmov();
    test_invalid();
    test_stack();
    do_reset();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
